mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one physical memory port between the pipeline's instruction port (port A, read-only) and data port (port B, read/write). Sits between the LC-3b pipelined datapath and the cache/physical memory. Serialises requests with a three-state FSM. Routes the single downstream response back to the granted requester.

## Interface
Parameters: none. Widths come from the shared package: word is 16 bits, wmask is 2 bits.

- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- a_read  in  1  instruction read request; held until a_resp
- a_address  in  16  instruction address
- a_rdata  out  16  instruction read data
- a_resp  out  1  one-cycle completion pulse for port A
- b_read  in  1  data read request; held until b_resp
- b_write  in  1  data write request; held until b_resp
- b_wmask  in  2  byte write mask
- b_address  in  16  data address
- b_wdata  in  16  data write value
- b_rdata  out  16  data read data
- b_resp  out  1  one-cycle completion pulse for port B
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_wmask  out  2  downstream byte mask
- mem_address  out  16  downstream address
- mem_wdata  out  16  downstream write data
- mem_rdata  in  16  downstream read data
- mem_resp  in  1  downstream completion, one cycle

## Operation
- FSM states: IDLE, SERVE_A, SERVE_B.
- IDLE transitions:
  - Only A pending (a_read) -> SERVE_A.
  - Only B pending (b_read | b_write) -> SERVE_B.
  - Both pending -> winner per Configuration.
  - Nothing pending -> stay in IDLE.
- On grant, latch the winner's request into output registers: read, write, wmask, address, wdata.
  - Port A grant forces write=0 and wmask=2'b11.
- SERVE_x: the latched outputs are held constant until mem_resp. Later changes on the requester's inputs are ignored.
- SERVE_x with mem_resp=1 -> IDLE. mem_* strobes clear on that same edge.
- Response routing is combinational:
  - a_resp = mem_resp & (state==SERVE_A); b_resp = mem_resp & (state==SERVE_B).
  - a_rdata and b_rdata both equal mem_rdata.
- b_read and b_write both high: illegal input. Write wins; mem_read=0.
- mem_resp in IDLE: ignored; no resp is generated.
- Reset values: state=IDLE; mem_read=mem_write=0; mem_wmask=0; mem_address=0; mem_wdata=0; last-served flag = A.

## Timing
- Request first seen in IDLE at cycle 0 -> mem_* asserted from cycle 1.
- mem_resp at cycle k -> requester resp at cycle k, with rdata valid in the same cycle. FSM is in IDLE at cycle k+1.
- Minimum gap: one IDLE cycle between back-to-back transactions.
  - Best-case occupancy is 2 cycles plus downstream latency.
- A request still asserted at cycle k+1 is treated as a new request. Requesters must drop read/write on the edge that samples resp.
- Reset mid-transaction: IDLE and all strobes low on the next edge. No resp is issued for the aborted access, even if mem_resp arrives that cycle.

## Configuration
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-served flag updates on every grant.
  - On a simultaneous request, the port not served last wins.
  - Reset value of the flag is A, so B wins the first tie.
- Undefined:
  - Fixed priority: B always wins ties, so the older memory-stage instruction goes first.
  - No flag register is present.

## Structure
- Shared package lc3b_types holds:
  - lc3b_word (16 bits) and lc3b_mem_wmask (2 bits).
  - New enum lc3b_arb_state with values IDLE, SERVE_A, SERVE_B.
- One combinational sub-module, arb_pick:
  - Inputs: req_a, req_b, last_served.
  - Outputs: grant_a, grant_b.
  - Contains the only code that the macro switches.
- Top-level module contains the FSM, the output latch registers and the response routing.

## Test plan
- A-only read at 16'h0040, mem_resp 3 cycles after mem_read, mem_rdata=16'h1234:
  - mem_read rises at cycle 1 with address 16'h0040.
  - a_resp pulses at cycle 4 with a_rdata=16'h1234; b_resp stays 0.
- B write, address 16'h2000, wdata 16'hBEEF, wmask 2'b01:
  - mem_write=1 and mem_wmask=2'b01 held until mem_resp.
  - b_resp pulses once; mem_read stays 0 throughout.
- A and B both asserted from reset, each held until its resp:
  - Macro undefined: order is B then A, with an IDLE cycle between.
  - Macro defined: order is B then A, then alternating on repeated ties.
- Grant A, then change a_address to 16'hFFFF before mem_resp:
  - mem_address remains the latched original value.
- reset asserted in SERVE_B with mem_resp=1 in the same cycle:
  - b_resp=0 and all mem_* strobes are 0 next cycle.
  - State is IDLE.
- b_read and b_write both 1:
  - mem_write=1, mem_read=0.
  - Stray mem_resp while in IDLE produces no a_resp or b_resp.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_types : shared LC-3b word/mask types and memory arbiter state encoding
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } lc3b_arb_state;

  // Encoding of the last-served flag
  localparam logic c_SERVED_A = 1'b0;
  localparam logic c_SERVED_B = 1'b1;

  localparam lc3b_mem_wmask c_WMASK_FULL = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// arb_pick : combinational grant selection between ports A and B
// Config   : MEM_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed B priority
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module arb_pick
  import lc3b_types::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_served,
  output logic grant_a,
  output logic grant_b
);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic w_tie;
  assign w_tie = req_a & req_b;

  // On a tie the port that was not served last goes first
  assign grant_a = req_a & (~req_b | (w_tie & (last_served == c_SERVED_B)));
  assign grant_b = req_b & (~req_a | (w_tie & (last_served == c_SERVED_A)));
`else
  logic w_unused_last_served;
  assign w_unused_last_served = last_served;

  // B is the older memory-stage instruction, so it always wins a tie
  assign grant_a = req_a & ~req_b;
  assign grant_b = req_b;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : shares one memory port between instruction (A) and data (B)
// Config      : MEM_ARBITER_ROUND_ROBIN_EN enables round-robin tie breaking
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          a_read,
  input  lc3b_word      a_address,
  output lc3b_word      a_rdata,
  output logic          a_resp,
  input  logic          b_read,
  input  logic          b_write,
  input  lc3b_mem_wmask b_wmask,
  input  lc3b_word      b_address,
  input  lc3b_word      b_wdata,
  output lc3b_word      b_rdata,
  output logic          b_resp,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_mem_wmask mem_wmask,
  output lc3b_word      mem_address,
  output lc3b_word      mem_wdata,
  input  lc3b_word      mem_rdata,
  input  logic          mem_resp
);

  lc3b_arb_state r_state;
  lc3b_arb_state w_next_state;

  logic          r_mem_read;
  logic          r_mem_write;
  lc3b_mem_wmask r_mem_wmask;
  lc3b_word      r_mem_address;
  lc3b_word      r_mem_wdata;

  logic w_req_a;
  logic w_req_b;
  logic w_grant_a;
  logic w_grant_b;
  logic w_last_served;
  logic w_idle;

  assign w_req_a = a_read;
  assign w_req_b = b_read | b_write;
  assign w_idle  = (r_state == IDLE);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic r_last_served;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_served <= c_SERVED_A;
    end else if (w_idle && (w_grant_a || w_grant_b)) begin
      r_last_served <= w_grant_b ? c_SERVED_B : c_SERVED_A;
    end
  end

  assign w_last_served = r_last_served;
`else
  assign w_last_served = c_SERVED_A;
`endif

  arb_pick u_pick (
    .req_a       (w_req_a),
    .req_b       (w_req_b),
    .last_served (w_last_served),
    .grant_a     (w_grant_a),
    .grant_b     (w_grant_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_b) begin
          w_next_state = SERVE_B;
        end else if (w_grant_a) begin
          w_next_state = SERVE_A;
        end
      end
      SERVE_A, SERVE_B: begin
        if (mem_resp) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request latch: captured on grant, frozen while serving, strobes dropped on resp
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_wmask   <= '0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
    end else if (w_idle) begin
      if (w_grant_b) begin
        r_mem_read    <= b_read & ~b_write;
        r_mem_write   <= b_write;
        r_mem_wmask   <= b_wmask;
        r_mem_address <= b_address;
        r_mem_wdata   <= b_wdata;
      end else if (w_grant_a) begin
        r_mem_read    <= 1'b1;
        r_mem_write   <= 1'b0;
        r_mem_wmask   <= c_WMASK_FULL;
        r_mem_address <= a_address;
        r_mem_wdata   <= '0;
      end
    end else if (mem_resp) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_wmask   = r_mem_wmask;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;

  // Reset masks the response so an aborted access never completes
  assign a_resp  = mem_resp & (r_state == SERVE_A) & ~reset;
  assign b_resp  = mem_resp & (r_state == SERVE_B) & ~reset;
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        a_read;
  logic [15:0] a_address;
  logic [15:0] a_rdata;
  logic        a_resp;
  logic        b_read;
  logic        b_write;
  logic [1:0]  b_wmask;
  logic [15:0] b_address;
  logic [15:0] b_wdata;
  logic [15:0] b_rdata;
  logic        b_resp;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  int checks;
  int errors;

  mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_read      (a_read),
    .a_address   (a_address),
    .a_rdata     (a_rdata),
    .a_resp      (a_resp),
    .b_read      (b_read),
    .b_write     (b_write),
    .b_wmask     (b_wmask),
    .b_address   (b_address),
    .b_wdata     (b_wdata),
    .b_rdata     (b_rdata),
    .b_resp      (b_resp),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    a_read    = 1'b0;
    a_address = 16'h0000;
    b_read    = 1'b0;
    b_write   = 1'b0;
    b_wmask   = 2'b00;
    b_address = 16'h0000;
    b_wdata   = 16'h0000;
    mem_rdata = 16'h0000;
    mem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
    checks++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
    checks++;
    if (mem_wmask !== 2'b00) begin errors++; $display("FAIL reset_mem_wmask got %b exp 00", mem_wmask); end
    checks++;
    if (mem_address !== 16'h0000) begin errors++; $display("FAIL reset_mem_address got %h exp 0000", mem_address); end
    checks++;
    if (mem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0000", mem_wdata); end
    checks++;
    if ({a_resp, b_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got %b exp 00", {a_resp, b_resp}); end
  endtask

  task automatic test_a_read();
    do_reset();
    a_read    = 1'b1;
    a_address = 16'h0040;
    step();
    checks++;
    if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL a_strobe_c1 got %b exp 10", {mem_read, mem_write}); end
    checks++;
    if (mem_address !== 16'h0040) begin errors++; $display("FAIL a_addr_c1 got %h exp 0040", mem_address); end
    checks++;
    if (mem_wmask !== 2'b11) begin errors++; $display("FAIL a_wmask got %b exp 11", mem_wmask); end
    step();
    step();
    checks++;
    if ({mem_read, a_resp} !== 2'b10) begin errors++; $display("FAIL a_hold_c3 got %b exp 10", {mem_read, a_resp}); end
    step();
    mem_resp  = 1'b1;
    mem_rdata = 16'h1234;
    a_read    = 1'b0;
    settle();
    checks++;
    if ({a_resp, b_resp} !== 2'b10) begin errors++; $display("FAIL a_resp_c4 got %b exp 10", {a_resp, b_resp}); end
    checks++;
    if (a_rdata !== 16'h1234) begin errors++; $display("FAIL a_rdata_c4 got %h exp 1234", a_rdata); end
    step();
    mem_resp = 1'b0;
    settle();
    checks++;
    if ({mem_read, a_resp} !== 2'b00) begin errors++; $display("FAIL a_done_c5 got %b exp 00", {mem_read, a_resp}); end
  endtask

  task automatic test_b_write();
    int resp_count;
    int read_seen;
    do_reset();
    resp_count = 0;
    read_seen  = 0;
    b_write   = 1'b1;
    b_address = 16'h2000;
    b_wdata   = 16'hBEEF;
    b_wmask   = 2'b01;
    for (int c = 0; c < 3; c++) begin
      step();
      if (mem_read) read_seen++;
      if (b_resp) resp_count++;
      checks++;
      if ({mem_write, mem_wmask, mem_address, mem_wdata} !== {1'b1, 2'b01, 16'h2000, 16'hBEEF}) begin
        errors++;
        $display("FAIL b_write_hold cyc %0d got w=%b m=%b a=%h d=%h exp w=1 m=01 a=2000 d=beef",
                 c, mem_write, mem_wmask, mem_address, mem_wdata);
      end
    end
    mem_resp = 1'b1;
    b_write  = 1'b0;
    settle();
    if (mem_read) read_seen++;
    if (b_resp) resp_count++;
    checks++;
    if (a_resp !== 1'b0) begin errors++; $display("FAIL b_write_a_resp got %b exp 0", a_resp); end
    for (int c = 0; c < 2; c++) begin
      step();
      mem_resp = 1'b0;
      settle();
      if (mem_read) read_seen++;
      if (b_resp) resp_count++;
    end
    checks++;
    if (resp_count !== 1) begin errors++; $display("FAIL b_write_resp_count got %0d exp 1", resp_count); end
    checks++;
    if (read_seen !== 0) begin errors++; $display("FAIL b_write_mem_read got %0d cycles high exp 0", read_seen); end
    checks++;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL b_write_clear got %b exp 0", mem_write); end
  endtask

  task automatic test_tie();
    logic [15:0] exp_fourth;
    clear_inputs();
    reset     = 1'b1;
    a_read    = 1'b1;
    a_address = 16'h1111;
    b_read    = 1'b1;
    b_address = 16'h2222;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({mem_read, mem_address} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL tie_first got r=%b a=%h exp r=1 a=2222", mem_read, mem_address); end
    mem_resp = 1'b1;
    b_read   = 1'b0;
    settle();
    checks++;
    if ({a_resp, b_resp} !== 2'b01) begin errors++; $display("FAIL tie_first_resp got %b exp 01", {a_resp, b_resp}); end
    step();
    mem_resp = 1'b0;
    settle();
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL tie_gap got %b exp 0", mem_read); end
    step();
    checks++;
    if ({mem_read, mem_address} !== {1'b1, 16'h1111}) begin errors++; $display("FAIL tie_second got r=%b a=%h exp r=1 a=1111", mem_read, mem_address); end
    mem_resp = 1'b1;
    b_read   = 1'b1;
    settle();
    checks++;
    if ({a_resp, b_resp} !== 2'b10) begin errors++; $display("FAIL tie_second_resp got %b exp 10", {a_resp, b_resp}); end
    step();
    mem_resp = 1'b0;
    step();
    checks++;
    if (mem_address !== 16'h2222) begin errors++; $display("FAIL tie_third got %h exp 2222", mem_address); end
    mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    step();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    exp_fourth = 16'h1111;
`else
    exp_fourth = 16'h2222;
`endif
    checks++;
    if ({mem_read, mem_address} !== {1'b1, exp_fourth}) begin errors++; $display("FAIL tie_fourth got r=%b a=%h exp r=1 a=%h", mem_read, mem_address, exp_fourth); end
    mem_resp = 1'b1;
    a_read   = 1'b0;
    b_read   = 1'b0;
    step();
    mem_resp = 1'b0;
  endtask

  task automatic test_latch();
    do_reset();
    a_read    = 1'b1;
    a_address = 16'h0100;
    step();
    a_address = 16'hFFFF;
    step();
    step();
    checks++;
    if (mem_address !== 16'h0100) begin errors++; $display("FAIL latch_addr got %h exp 0100", mem_address); end
    mem_resp = 1'b1;
    a_read   = 1'b0;
    step();
    mem_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    b_read    = 1'b1;
    b_address = 16'h3000;
    step();
    reset    = 1'b1;
    mem_resp = 1'b1;
    settle();
    checks++;
    if (b_resp !== 1'b0) begin errors++; $display("FAIL reset_mid_resp got %b exp 0", b_resp); end
    step();
    reset  = 1'b0;
    b_read = 1'b0;
    settle();
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_mid_strobes got %b exp 00", {mem_read, mem_write}); end
    // mem_resp still high: only an IDLE state keeps both responses low
    checks++;
    if ({a_resp, b_resp} !== 2'b00) begin errors++; $display("FAIL reset_mid_idle got %b exp 00", {a_resp, b_resp}); end
    step();
    mem_resp = 1'b0;
  endtask

  task automatic test_illegal_rw();
    do_reset();
    b_read    = 1'b1;
    b_write   = 1'b1;
    b_address = 16'h4000;
    b_wdata   = 16'h5A5A;
    b_wmask   = 2'b10;
    step();
    checks++;
    if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL rw_strobes got %b exp 01", {mem_read, mem_write}); end
    mem_resp = 1'b1;
    b_read   = 1'b0;
    b_write  = 1'b0;
    settle();
    checks++;
    if (b_resp !== 1'b1) begin errors++; $display("FAIL rw_resp got %b exp 1", b_resp); end
    step();
    settle();
    checks++;
    if ({a_resp, b_resp} !== 2'b00) begin errors++; $display("FAIL stray_resp got %b exp 00", {a_resp, b_resp}); end
    step();
    mem_resp = 1'b0;
    settle();
    checks++;
    if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL stray_idle got %b exp 00", {mem_read, mem_write}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_a_read();
    test_b_write();
    test_tie();
    test_latch();
    test_reset_mid();
    test_illegal_rw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
